// File: rtl/conv_output_collector.sv
// conv_output_collector: requantizes the convolution accumulator stream and
// assembles an OUT_H x OUT_W feature-map buffer with a registered read port.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   start           arm a new frame (IDLE or READY)
//   in_pixel        signed accumulator value, qualified by in_valid
//   in_valid        one pulse per pixel, raster order, no backpressure
//   conv_done       producer finished its frame
//   frame_done      buffer complete or closed early (level)
//   err_short       conv_done arrived before the frame was full
//   err_extra       pixel arrived while READY (sticky until start)
//   sat_cnt         number of clamped pixels in the current frame
//   rd_en           read request; rd_row/rd_col select the entry
//   rd_data         read result, one cycle after rd_en
//   rd_valid        one-cycle pulse per accepted request
//
// Build option: define CONV_COLLECT_RELU_EN to force negative values to 0
// before clamping (such values do not count as saturated).

module conv_output_collector #(
   parameter int ACC_WIDTH  = 32,
   parameter int DATA_WIDTH = 8,
   parameter int OUT_H      = 3,
   parameter int OUT_W      = 3,
   parameter int SHIFT      = 0
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start,
   input  logic signed [ACC_WIDTH-1:0]           in_pixel,
   input  logic                                  in_valid,
   input  logic                                  conv_done,
   output logic                                  frame_done,
   output logic                                  err_short,
   output logic                                  err_extra,
   output logic [$clog2(OUT_H*OUT_W+1)-1:0]      sat_cnt,
   input  logic                                  rd_en,
   input  logic [$clog2(OUT_H)+1-1:0]            rd_row,
   input  logic [$clog2(OUT_W)+1-1:0]            rd_col,
   output logic signed [DATA_WIDTH-1:0]          rd_data,
   output logic                                  rd_valid
);

   localparam int N   = OUT_H * OUT_W;
   localparam int AW  = (N > 1) ? $clog2(N) : 1;
   localparam int RW  = $clog2(OUT_H) + 1;
   localparam int CW  = $clog2(OUT_W) + 1;
   localparam int SCW = $clog2(N + 1);

   localparam logic signed [ACC_WIDTH-1:0] MAXV =
      ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
`ifndef CONV_COLLECT_RELU_EN
   // Two's complement: ~(2^(DW-1)-1) == -2^(DW-1)
   localparam logic signed [ACC_WIDTH-1:0] MINV = ~MAXV;
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_READY
   } state_t;

   state_t                         r_state;
   logic [RW-1:0]                  r_row;
   logic [CW-1:0]                  r_col;
   logic signed [DATA_WIDTH-1:0]   r_buf [N];

   logic signed [ACC_WIDTH-1:0]    w_shift;
   logic signed [DATA_WIDTH-1:0]   w_q;
   logic                           w_clamp;
   logic                           w_last;
   logic [AW-1:0]                  w_wr_idx;
   logic [AW-1:0]                  w_rd_idx;
   logic                           w_rd_in;

   assign w_shift = in_pixel >>> SHIFT;

   always_comb begin
      w_q     = w_shift[DATA_WIDTH-1:0];
      w_clamp = 1'b0;
`ifdef CONV_COLLECT_RELU_EN
      if (w_shift < 0) begin
         w_q = '0;
      end else if (w_shift > MAXV) begin
         w_q     = DATA_WIDTH'(MAXV);
         w_clamp = 1'b1;
      end
`else
      if (w_shift > MAXV) begin
         w_q     = DATA_WIDTH'(MAXV);
         w_clamp = 1'b1;
      end else if (w_shift < MINV) begin
         w_q     = DATA_WIDTH'(MINV);
         w_clamp = 1'b1;
      end
`endif
   end

   assign w_last   = (r_row == RW'(OUT_H - 1)) && (r_col == CW'(OUT_W - 1));
   assign w_wr_idx = AW'(32'(r_row) * 32'(OUT_W) + 32'(r_col));
   assign w_rd_idx = AW'(32'(rd_row) * 32'(OUT_W) + 32'(rd_col));
   assign w_rd_in  = (32'(rd_row) < 32'(OUT_H)) && (32'(rd_col) < 32'(OUT_W));

   // Buffer has no reset; contents are undefined until written.
   always_ff @(posedge clk) begin
      if (r_state == S_COLLECT && in_valid)
         r_buf[w_wr_idx] <= w_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_row      <= '0;
         r_col      <= '0;
         frame_done <= 1'b0;
         err_short  <= 1'b0;
         err_extra  <= 1'b0;
         sat_cnt    <= '0;
         rd_data    <= '0;
         rd_valid   <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         if (rd_en && r_state == S_READY) begin
            rd_valid <= 1'b1;
            rd_data  <= w_rd_in ? r_buf[w_rd_idx] : '0;
         end

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state   <= S_COLLECT;
                  r_row     <= '0;
                  r_col     <= '0;
                  sat_cnt   <= '0;
                  err_short <= 1'b0;
                  err_extra <= 1'b0;
               end
            end
            S_COLLECT: begin
               if (in_valid) begin
                  if (w_clamp && sat_cnt != '1)
                     sat_cnt <= sat_cnt + SCW'(1);
                  if (r_col == CW'(OUT_W - 1)) begin
                     r_col <= '0;
                     r_row <= r_row + RW'(1);
                  end else begin
                     r_col <= r_col + CW'(1);
                  end
               end
               if (in_valid && w_last) begin
                  r_state    <= S_READY;
                  frame_done <= 1'b1;
               end else if (conv_done) begin
                  // Early close: unwritten entries keep old contents
                  r_state    <= S_READY;
                  frame_done <= 1'b1;
                  err_short  <= 1'b1;
               end
            end
            S_READY: begin
               if (in_valid)
                  err_extra <= 1'b1;
               if (start) begin
                  r_state    <= S_COLLECT;
                  r_row      <= '0;
                  r_col      <= '0;
                  sat_cnt    <= '0;
                  err_short  <= 1'b0;
                  err_extra  <= 1'b0;
                  frame_done <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_output_collector.sv
// Scoreboard bench for conv_output_collector: two instances share stimulus,
// one with SHIFT=0 and one with SHIFT=2; read results are checked by a monitor.

module tb_conv_output_collector;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic signed [31:0] in_pixel;
   logic              in_valid;
   logic              conv_done;
   logic              rd_en;
   logic [2:0]        rd_row;
   logic [2:0]        rd_col;

   logic              fd0, es0, ee0, rv0;
   logic              fd1, es1, ee1, rv1;
   logic [3:0]        sc0, sc1;
   logic signed [7:0] rd0, rd1;

   int ntests = 0;
   int nfail  = 0;
   int q0[$];
   int q1[$];
   int me0, me1;

   int b0[9], b1[9];
   int b0_sat4, b1_sat4, b0_sat, b1_sat;
   int old0, old1;
   int n0_00, n1_00, n0_11, n1_11, n0_22, n1_22;

   always #5 clk = ~clk;

   conv_output_collector #(.SHIFT(0)) u0 (
      .clk(clk), .rst(rst), .start(start), .in_pixel(in_pixel),
      .in_valid(in_valid), .conv_done(conv_done), .frame_done(fd0),
      .err_short(es0), .err_extra(ee0), .sat_cnt(sc0), .rd_en(rd_en),
      .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd0), .rd_valid(rv0)
   );

   conv_output_collector #(.SHIFT(2)) u1 (
      .clk(clk), .rst(rst), .start(start), .in_pixel(in_pixel),
      .in_valid(in_valid), .conv_done(conv_done), .frame_done(fd1),
      .err_short(es1), .err_extra(ee1), .sat_cnt(sc1), .rd_en(rd_en),
      .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd1), .rd_valid(rv1)
   );

   task automatic chk(input string name, input int got, input int exp);
      ntests++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rv0) begin
         if (q0.size() == 0) begin
            chk("rd0_unexpected", 1, 0);
         end else begin
            me0 = q0.pop_front();
            chk("rd0_data", int'(rd0), me0);
         end
      end
      if (rv1) begin
         if (q1.size() == 0) begin
            chk("rd1_unexpected", 1, 0);
         end else begin
            me1 = q1.pop_front();
            chk("rd1_data", int'(rd1), me1);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic px(input int v);
      in_pixel = v;
      in_valid = 1'b1;
      tick();
   endtask

   task automatic idle();
      in_valid = 1'b0;
      conv_done = 1'b0;
      start = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic rd(input int r, input int c, input int e0, input int e1);
      rd_row = 3'(r);
      rd_col = 3'(c);
      rd_en = 1'b1;
      q0.push_back(e0);
      q1.push_back(e1);
      tick();
      rd_en = 1'b0;
   endtask

   task automatic flags(input string tag, input int fd, input int es,
                        input int ee);
      chk({tag, "_fd0"}, int'(fd0), fd);
      chk({tag, "_fd1"}, int'(fd1), fd);
      chk({tag, "_es0"}, int'(es0), es);
      chk({tag, "_es1"}, int'(es1), es);
      chk({tag, "_ee0"}, int'(ee0), ee);
      chk({tag, "_ee1"}, int'(ee1), ee);
   endtask

   initial begin
`ifdef CONV_COLLECT_RELU_EN
      b0 = '{127, 0, 127, 0, 100, 0, 0, 127, 0};
      b1 = '{75, 0, 31, 0, 25, 0, 0, 127, 0};
      b0_sat4 = 1; b1_sat4 = 0; b0_sat = 2; b1_sat = 1;
      old0 = 0; old1 = 0;
      n0_00 = 0; n1_00 = 0; n0_11 = 0; n1_11 = 0; n0_22 = 0; n1_22 = 0;
`else
      b0 = '{127, -128, 127, -128, 100, -5, -50, 127, -128};
      b1 = '{75, -75, 31, -32, 25, -2, -13, 127, -128};
      b0_sat4 = 2; b1_sat4 = 0; b0_sat = 4; b1_sat = 2;
      old0 = -128; old1 = -128;
      n0_00 = -1; n1_00 = -1; n0_11 = -5; n1_11 = -2;
      n0_22 = -9; n1_22 = -3;
`endif
      rst = 1'b1;
      idle();
      in_pixel = 0;
      rd_en = 1'b0;
      rd_row = '0;
      rd_col = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Reset state
      flags("rst", 0, 0, 0);
      chk("rst_sat0", int'(sc0), 0);
      chk("rst_rv0", int'(rv0), 0);
      chk("rst_rd0", int'(rd0), 0);

      // Nominal frame 1..9
      do_start();
      for (int i = 1; i <= 8; i++) px(i);
      chk("nom_fd_early", int'(fd0), 0);
      px(9);
      idle();
      flags("nom", 1, 0, 0);
      chk("nom_sat0", int'(sc0), 0);
      chk("nom_sat1", int'(sc1), 0);
      rd(0, 0, 1, 0);
      rd(1, 2, 6, 1);
      rd(2, 2, 9, 2);
      tick();

      // Saturation / shift / ReLU frame
      do_start();
      chk("start_clr_fd0", int'(fd0), 0);
      px(300); px(-300); px(127); px(-128);
      in_valid = 1'b0;
      chk("sat4_0", int'(sc0), b0_sat4);
      chk("sat4_1", int'(sc1), b1_sat4);
      px(100); px(-5); px(-50); px(1000); px(-1000);
      idle();
      flags("satf", 1, 0, 0);
      chk("satf_sat0", int'(sc0), b0_sat);
      chk("satf_sat1", int'(sc1), b1_sat);
      for (int i = 0; i < 9; i++) rd(i / 3, i % 3, b0[i], b1[i]);
      tick();

      // Short frame: 5 pixels then conv_done
      do_start();
      px(10); px(20); px(30); px(40); px(50);
      idle();
      chk("short_fd_pre", int'(fd0), 0);
      conv_done = 1'b1;
      tick();
      idle();
      flags("short", 1, 1, 0);
      rd(1, 1, 50, 12);
      rd(2, 2, old0, old1);
      tick();

      // Full frame, conv_done with final pixel, then extra pixel
      do_start();
      for (int i = 1; i <= 8; i++) px(i);
      conv_done = 1'b1;
      px(9);
      idle();
      flags("full", 1, 0, 0);
      px(77);
      idle();
      flags("extra", 1, 0, 1);
      rd(0, 0, 1, 0);
      rd(3, 0, 0, 0);
      rd(0, 3, 0, 0);
      rd(7, 7, 0, 0);
      tick();

      // Restart, partial frame, read while collecting, reset mid-frame
      do_start();
      flags("restart", 0, 0, 0);
      px(1000); px(2); px(3); px(4);
      idle();
      chk("mid_sat0", int'(sc0), 1);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("coll_rv0", int'(rv0), 0);
      #2;
      rst = 1'b1;
      #1;
      flags("arst", 0, 0, 0);
      chk("arst_sat0", int'(sc0), 0);
      chk("arst_rd0", int'(rd0), 0);
      chk("arst_rv0", int'(rv0), 0);
      tick();
      rst = 1'b0;
      tick();

      // IDLE ignores pixels, including the start cycle
      px(55);
      start = 1'b1;
      px(99);
      start = 1'b0;
      for (int i = 1; i <= 9; i++) px(-i);
      idle();
      flags("after_rst", 1, 0, 0);
      chk("after_rst_sat0", int'(sc0), 0);
      chk("after_rst_sat1", int'(sc1), 0);
      rd(0, 0, n0_00, n1_00);
      rd(1, 1, n0_11, n1_11);
      rd(2, 2, n0_22, n1_22);
      tick();
      tick();

      chk("pending0", q0.size(), 0);
      chk("pending1", q1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
